// File: rtl/iobank_ctrl.sv
// iobank_ctrl: per-pad routing between hard-wired peripheral functions and register-controlled GPIO,
// with synchronised inputs, edge interrupts and an optional debounce filter (define IOBANK_DEBOUNCE_EN).
module iobank_ctrl #(
    parameter int NPADS = 10,
    parameter int DEB_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             reg_req,
    input  logic             reg_we,
    input  logic [2:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             reg_ack,
    input  logic [NPADS-1:0] func_out,
    input  logic [NPADS-1:0] func_oe,
    output logic [NPADS-1:0] func_in,
    input  logic [NPADS-1:0] pad_i,
    output logic [NPADS-1:0] pad_o,
    output logic [NPADS-1:0] pad_oe,
    output logic             irq
);

    localparam logic [2:0] A_MODE     = 3'd0;
    localparam logic [2:0] A_GPIO_OUT = 3'd1;
    localparam logic [2:0] A_GPIO_OE  = 3'd2;
    localparam logic [2:0] A_GPIO_IN  = 3'd3;
    localparam logic [2:0] A_IRQ_EN   = 3'd4;
    localparam logic [2:0] A_IRQ_STAT = 3'd5;
    localparam logic [2:0] A_EDGE_SEL = 3'd6;

    logic [NPADS-1:0] mode, gpio_out, gpio_oe, irq_en, irq_stat, edge_sel;
    logic [NPADS-1:0] sync1, sync2, filt, filt_q;
    logic [NPADS-1:0] edge_set, w1c_mask, wdat;
    logic [31:0]      rd_word;
    logic             wr;
    logic             unused_wdata;

    assign wdat         = reg_wdata[NPADS-1:0];
    assign unused_wdata = ^reg_wdata;
    assign wr           = reg_req & reg_we;

    assign pad_o   = (mode & gpio_out) | (~mode & func_out);
    assign pad_oe  = (mode & gpio_oe)  | (~mode & func_oe);
    assign func_in = pad_i;

    assign edge_set = (filt & ~filt_q & edge_sel) | (~filt & filt_q & ~edge_sel);
    assign w1c_mask = (wr && reg_addr == A_IRQ_STAT) ? wdat : '0;
    assign irq      = |(irq_stat & irq_en);

    always_comb begin
        rd_word = '0;
        case (reg_addr)
            A_MODE:     rd_word[NPADS-1:0] = mode;
            A_GPIO_OUT: rd_word[NPADS-1:0] = gpio_out;
            A_GPIO_OE:  rd_word[NPADS-1:0] = gpio_oe;
            A_GPIO_IN:  rd_word[NPADS-1:0] = filt;
            A_IRQ_EN:   rd_word[NPADS-1:0] = irq_en;
            A_IRQ_STAT: rd_word[NPADS-1:0] = irq_stat;
            A_EDGE_SEL: rd_word[NPADS-1:0] = edge_sel;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mode      <= '0;
            gpio_out  <= '0;
            gpio_oe   <= '0;
            irq_en    <= '0;
            irq_stat  <= '0;
            edge_sel  <= '0;
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ack   <= reg_req;
            reg_rdata <= reg_req ? rd_word : '0;
            if (wr) begin
                case (reg_addr)
                    A_MODE:     mode     <= wdat;
                    A_GPIO_OUT: gpio_out <= wdat;
                    A_GPIO_OE:  gpio_oe  <= wdat;
                    A_IRQ_EN:   irq_en   <= wdat;
                    A_EDGE_SEL: edge_sel <= wdat;
                    default:    ;
                endcase
            end
            // a new edge wins over a same-cycle clear
            irq_stat <= (irq_stat & ~w1c_mask) | edge_set;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1  <= '0;
            sync2  <= '0;
            filt_q <= '0;
        end else begin
            sync1  <= pad_i;
            sync2  <= sync1;
            filt_q <= filt;
        end
    end

`ifdef IOBANK_DEBOUNCE_EN
    logic [DEB_W-1:0] deb_cnt [NPADS];

    // a change is accepted only after 2^DEB_W consecutive differing cycles
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            filt <= '0;
            for (int i = 0; i < NPADS; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NPADS; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == {DEB_W{1'b1}}) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end
`else
    localparam int unused_deb_w = DEB_W;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) filt <= '0;
        else      filt <= sync2;
    end
`endif

endmodule

// File: tb/tb_iobank_ctrl.sv
// Randomised scoreboard bench for iobank_ctrl against a cycle-level reference model of the register map and input chain.
module tb_iobank_ctrl;
    localparam int NP = 10;
    localparam int DW = 4;
`ifdef IOBANK_DEBOUNCE_EN
    localparam int LAT = 4 + (1 << DW) - 1;
`else
    localparam int LAT = 4;
`endif

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          reg_req = 1'b0, reg_we = 1'b0;
    logic [2:0]    reg_addr = '0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          reg_ack;
    logic [NP-1:0] func_out = '0, func_oe = '0, func_in, pad_i = '0, pad_o, pad_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    iobank_ctrl #(.NPADS(NP), .DEB_W(DW)) dut (
        .clk(clk), .arst(arst), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .func_out(func_out), .func_oe(func_oe), .func_in(func_in),
        .pad_i(pad_i), .pad_o(pad_o), .pad_oe(pad_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [NP-1:0] m_mode, m_out, m_oe, m_en, m_stat, m_esel;
    logic [NP-1:0] m_s1, m_s2, m_filt, m_filtq;
    logic [NP-1:0] m_win [16];
    logic [31:0]   exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] pick(input logic [NP-1:0] sel, input logic [NP-1:0] a,
                                           input logic [NP-1:0] b);
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = sel[i] ? a[i] : b[i];
        return r;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_mode = '0; m_out = '0; m_oe = '0; m_en = '0; m_stat = '0; m_esel = '0;
            m_s1 = '0; m_s2 = '0; m_filt = '0; m_filtq = '0;
            for (int j = 0; j < 16; j++) m_win[j] = '0;
            exp_q.delete();
        end else begin
            logic [NP-1:0] set, w;
            logic [31:0]   rv;
            set = '0;
            for (int i = 0; i < NP; i++)
                if (m_filt[i] != m_filtq[i] && m_filt[i] == m_esel[i]) set[i] = 1'b1;
            w = reg_wdata[NP-1:0];
            if (reg_req) begin
                case (reg_addr)
                    3'd0: rv = 32'(m_mode);
                    3'd1: rv = 32'(m_out);
                    3'd2: rv = 32'(m_oe);
                    3'd3: rv = 32'(m_filt);
                    3'd4: rv = 32'(m_en);
                    3'd5: rv = 32'(m_stat);
                    3'd6: rv = 32'(m_esel);
                    default: rv = 32'd0;
                endcase
                exp_q.push_back(rv);
                if (reg_we) begin
                    case (reg_addr)
                        3'd0: m_mode = w;
                        3'd1: m_out = w;
                        3'd2: m_oe = w;
                        3'd4: m_en = w;
                        3'd5: m_stat = m_stat & ~w;
                        3'd6: m_esel = w;
                        default: ;
                    endcase
                end
            end
            m_stat = m_stat | set;
            m_filtq = m_filt;
`ifdef IOBANK_DEBOUNCE_EN
            for (int j = 15; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = m_s2;
            for (int i = 0; i < NP; i++) begin
                bit all_other = 1'b1;
                for (int j = 0; j < 16; j++) if (m_win[j][i] == m_filt[i]) all_other = 1'b0;
                if (all_other) m_filt[i] = ~m_filt[i];
            end
`else
            m_filt = m_s2;
`endif
            m_s2 = m_s1;
            m_s1 = pad_i;
        end
    end

    // monitor
    always @(negedge clk) begin
        chk("pad_o", 32'(pad_o), 32'(pick(m_mode, m_out, func_out)));
        chk("pad_oe", 32'(pad_oe), 32'(pick(m_mode, m_oe, func_oe)));
        chk("func_in", 32'(func_in), 32'(pad_i));
        chk("irq", 32'(irq), 32'(|(m_stat & m_en)));
        if (reg_ack) begin
            if (exp_q.size() == 0) chk("spurious_ack", 32'(reg_ack), 32'd0);
            else chk("rdata", reg_rdata, exp_q.pop_front());
        end else if (exp_q.size() != 0) begin
            chk("missing_ack", 32'(reg_ack), 32'd1);
            exp_q.delete();
        end
    end

    task automatic reg_op(input logic we, input logic [2:0] a, input logic [31:0] d);
        reg_req = 1'b1; reg_we = we; reg_addr = a; reg_wdata = d;
        @(posedge clk); #1;
        reg_req = 1'b0; reg_we = 1'b0;
    endtask

    task automatic rd_const(input string name, input logic [2:0] a, input logic [31:0] exp);
        reg_op(1'b0, a, 32'd0);
        @(negedge clk);
        chk(name, reg_ack ? reg_rdata : 32'hDEAD_BEEF, exp);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        func_out = 10'h155; func_oe = 10'h3FF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pad_o", 32'(pad_o), 32'h155);
        chk("rst_pad_oe", 32'(pad_oe), 32'h3FF);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(reg_ack), 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        for (int a = 0; a < 8; a++) reg_op(1'b0, 3'(a), 32'd0);
        rd_const("rst_mode", 3'd0, 32'd0);

        // mode switch
        func_out = 10'h3FF; func_oe = 10'h000;
        reg_op(1'b1, 3'd0, 32'h0F0);
        reg_op(1'b1, 3'd1, 32'h0A0);
        reg_op(1'b1, 3'd2, 32'h030);
        @(negedge clk);
        chk("mix_pad_o", 32'(pad_o), 32'h3AF);
        chk("mix_pad_oe", 32'(pad_oe), 32'h030);
        @(posedge clk); #1;
        rd_const("rd_mode", 3'd0, 32'h0F0);
        rd_const("rd_addr7", 3'd7, 32'd0);

        // rising-edge interrupt on pad 3
        reg_op(1'b1, 3'd6, 32'h008);
        reg_op(1'b1, 3'd4, 32'h008);
        pad_i[3] = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("irq_before", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), 32'd1);
        @(posedge clk); #1;
        rd_const("stat_rise", 3'd5, 32'h008);
        reg_op(1'b1, 3'd5, 32'h008);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'd0);
        @(posedge clk); #1;

        // set/clear collision
        pad_i[3] = 1'b0;
        idle(LAT + 8);
        pad_i[3] = 1'b1;
        idle(LAT - 1);
        reg_op(1'b1, 3'd5, 32'h008);
        @(negedge clk);
        chk("irq_collide", 32'(irq), 32'd1);
        @(posedge clk); #1;
        rd_const("stat_collide", 3'd5, 32'h008);
        reg_op(1'b1, 3'd5, 32'h3FF);

`ifdef IOBANK_DEBOUNCE_EN
        reg_op(1'b1, 3'd6, 32'h001);
        pad_i[0] = 1'b1; idle(15); pad_i[0] = 1'b0; idle(40);
        rd_const("deb_short_in", 3'd3, 32'h008);
        rd_const("deb_short_stat", 3'd5, 32'h000);
        pad_i[0] = 1'b1; idle(16); idle(30);
        rd_const("deb_long_in", 3'd3, 32'h009);
`endif

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            reg_req   = ($urandom_range(0, 2) != 0);
            reg_we    = $urandom_range(0, 1) == 1;
            reg_addr  = 3'($urandom_range(0, 7));
            reg_wdata = $urandom;
            func_out  = NP'($urandom);
            func_oe   = NP'($urandom);
            if ($urandom_range(0, 3) == 0) pad_i[$urandom_range(0, NP - 1)] ^= 1'b1;
            @(posedge clk); #1;
        end
        reg_req = 1'b0; reg_we = 1'b0;
        idle(2);

        // reset during a read strobe
        reg_op(1'b1, 3'd0, 32'h3C3);
        reg_req = 1'b1; reg_we = 1'b0; reg_addr = 3'd0;
        #2 arst = 1'b1;
        @(posedge clk); #1;
        reg_req = 1'b0;
        @(negedge clk);
        chk("arst_ack", 32'(reg_ack), 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        rd_const("arst_mode", 3'd0, 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
